// File: rtl/sa_pkg.sv
// Shared constants, scheduler state encoding and accumulator sign extension
// for the systolic tile scheduler and its drain writer.
package sa_pkg;

    localparam int unsigned SA_N   = 4;     // default array dimension
    localparam int unsigned ACC_W  = 20;    // accumulator element width
    localparam int unsigned ADDR_W = 13;    // SRAM word address width (8k words)
    localparam int unsigned DATA_W = 32;    // result SRAM data width
    localparam int unsigned SA_TMO = 4095;  // default start-to-done watchdog limit

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_DRAIN = 3'd4,
        S_NEXT  = 3'd5,
        S_FIN   = 3'd6
    } sched_state_t;

    // Sign-extend one accumulator element to the result SRAM word width.
    function automatic logic [DATA_W-1:0] sext_acc(input logic [ACC_W-1:0] v);
        return {{(DATA_W - ACC_W){v[ACC_W-1]}}, v};
    endfunction

endpackage

// File: rtl/systolic_tile_sched_if.sv
// Host job-configuration channel of the tile scheduler.
//   master : host side, drives cfg_valid and the job fields, sees cfg_ready
//   slave  : scheduler side, accepts on cfg_valid & cfg_ready
interface systolic_tile_sched_if;

    logic                      cfg_valid;
    logic                      cfg_ready;
    logic [7:0]                cfg_mt;
    logic [7:0]                cfg_nt;
    logic [7:0]                cfg_k;
    logic [sa_pkg::ADDR_W-1:0] cfg_a_base;
    logic [sa_pkg::ADDR_W-1:0] cfg_b_base;
    logic [sa_pkg::ADDR_W-1:0] cfg_c_base;

    modport master (
        output cfg_valid, cfg_mt, cfg_nt, cfg_k, cfg_a_base, cfg_b_base, cfg_c_base,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_mt, cfg_nt, cfg_k, cfg_a_base, cfg_b_base, cfg_c_base,
        output cfg_ready
    );

endinterface

// File: rtl/sa_drain_writer.sv
// Drains one tile of N*N accumulators into the result SRAM, one word per cycle.
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   start            capture data and emit element 0 on the next cycle
//   abort            stop after the current cycle's write
//   base             result address of element 0 (wraps at ADDR_W)
//   data             flattened accumulators, element e at [e*ACC_W +: ACC_W]
//   last_c           high during the final write of the tile
//   c_wsbn/c_waddr/c_wdata  result SRAM write port (strobe active low)
module sa_drain_writer
    import sa_pkg::*;
#(
    parameter int unsigned N = SA_N
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_W-1:0]     base,
    input  logic [N*N*ACC_W-1:0]  data,
    output logic                  last_c,
    output logic                  c_wsbn,
    output logic [ADDR_W-1:0]     c_waddr,
    output logic [DATA_W-1:0]     c_wdata
);

    localparam int unsigned TILE_WORDS = N * N;
    localparam int unsigned CNT_W      = $clog2(TILE_WORDS);

    logic                 active;
    logic [CNT_W-1:0]     cnt;
    logic [N*N*ACC_W-1:0] snap;  // remaining elements, next one in the low ACC_W bits

    assign last_c = active && (cnt == CNT_W'(TILE_WORDS - 1));

    // Element sequencer: shift the snapshot down one element per write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            active  <= 1'b0;
            cnt     <= '0;
            snap    <= '0;
            c_wsbn  <= 1'b1;
            c_waddr <= '0;
            c_wdata <= '0;
        end else if (abort) begin
            active <= 1'b0;
            c_wsbn <= 1'b1;
        end else if (start) begin
            active  <= 1'b1;
            cnt     <= '0;
            snap    <= data >> ACC_W;
            c_wsbn  <= 1'b0;
            c_waddr <= base;
            c_wdata <= sext_acc(data[ACC_W-1:0]);
        end else if (active) begin
            if (last_c) begin
                active <= 1'b0;
                c_wsbn <= 1'b1;
            end else begin
                cnt     <= cnt + CNT_W'(1);
                snap    <= snap >> ACC_W;
                c_waddr <= c_waddr + ADDR_W'(1);
                c_wdata <= sext_acc(snap[ACC_W-1:0]);
            end
        end
    end

endmodule

// File: rtl/systolic_tile_sched.sv
// Tiled-matmul sequencer for a systolic NxN array. Walks an MT x NT grid of
// output tiles row-major: clear, start, wait for done, drain N*N results.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   cfg                        host job channel (slave modport)
//   abort                      cancel the running job
//   busy, done, err            job status (done is a 1-cycle pulse, err sticky)
//   sa_clear, sa_start         array control pulses
//   sa_k_param, sa_a_addr, sa_b_addr   per-tile array operands
//   sa_done, sa_out            array completion and flattened accumulators
//   c_wsbn, c_waddr, c_wdata   result SRAM write port
module systolic_tile_sched
    import sa_pkg::*;
#(
    parameter int unsigned N   = SA_N,
    parameter int unsigned TMO = SA_TMO
) (
    input  logic                  clk,
    input  logic                  rst_n,
    systolic_tile_sched_if.slave  cfg,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  sa_clear,
    output logic                  sa_start,
    output logic [7:0]            sa_k_param,
    output logic [ADDR_W-1:0]     sa_a_addr,
    output logic [ADDR_W-1:0]     sa_b_addr,
    input  logic                  sa_done,
    input  logic [N*N*ACC_W-1:0]  sa_out,
    output logic                  c_wsbn,
    output logic [ADDR_W-1:0]     c_waddr,
    output logic [DATA_W-1:0]     c_wdata
);

    localparam int unsigned EXT_W      = ADDR_W + 8;
    localparam int unsigned WD_W       = $clog2(TMO + 1);
    localparam int unsigned TILE_WORDS = N * N;

    sched_state_t      state;
    logic [7:0]        mt_q, nt_q, mt_idx, nt_idx;
    logic [ADDR_W-1:0] a_base, b_base, c_base;
    logic [WD_W-1:0]   wdog;

    logic              abort_c, bad_cfg_c, nt_wrap_c, last_tile_c, dw_start_c, dw_last_c;
    logic [7:0]        mt_nxt_c, nt_nxt_c;
    logic [EXT_W-1:0]  tile_num_c;
    logic [ADDR_W-1:0] tile_base_c;

    assign abort_c     = abort && (state != S_IDLE);
    assign bad_cfg_c   = (cfg.cfg_mt == 8'd0) || (cfg.cfg_nt == 8'd0) || (cfg.cfg_k == 8'd0);
    assign nt_wrap_c   = (nt_idx == nt_q - 8'd1);
    assign last_tile_c = nt_wrap_c && (mt_idx == mt_q - 8'd1);
    assign nt_nxt_c    = nt_wrap_c ? 8'd0 : nt_idx + 8'd1;
    assign mt_nxt_c    = nt_wrap_c ? mt_idx + 8'd1 : mt_idx;

    // Result base of the current tile; products kept wide, then wrapped to the SRAM.
    assign tile_num_c  = EXT_W'(mt_idx) * EXT_W'(nt_q) + EXT_W'(nt_idx);
    assign tile_base_c = c_base + ADDR_W'(tile_num_c * EXT_W'(TILE_WORDS));

    // The drain writer snapshots sa_out in the cycle the array reports done.
    assign dw_start_c  = (state == S_WAIT) && sa_done && !abort;

    // Scheduler FSM with tile counters, operand address generation and watchdog.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            cfg.cfg_ready <= 1'b1;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            sa_clear      <= 1'b0;
            sa_start      <= 1'b0;
            sa_k_param    <= '0;
            sa_a_addr     <= '0;
            sa_b_addr     <= '0;
            mt_q          <= '0;
            nt_q          <= '0;
            mt_idx        <= '0;
            nt_idx        <= '0;
            a_base        <= '0;
            b_base        <= '0;
            c_base        <= '0;
            wdog          <= '0;
        end else begin
            sa_clear <= 1'b0;
            sa_start <= 1'b0;
            done     <= 1'b0;
            if (abort_c) begin
                state         <= S_IDLE;
                busy          <= 1'b0;
                cfg.cfg_ready <= 1'b1;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (cfg.cfg_valid) begin
                            mt_q          <= cfg.cfg_mt;
                            nt_q          <= cfg.cfg_nt;
                            sa_k_param    <= cfg.cfg_k;
                            a_base        <= cfg.cfg_a_base;
                            b_base        <= cfg.cfg_b_base;
                            c_base        <= cfg.cfg_c_base;
                            sa_a_addr     <= cfg.cfg_a_base;
                            sa_b_addr     <= cfg.cfg_b_base;
                            mt_idx        <= '0;
                            nt_idx        <= '0;
                            busy          <= 1'b1;
                            cfg.cfg_ready <= 1'b0;
                            if (bad_cfg_c) begin
                                err   <= 1'b1;
                                done  <= 1'b1;
                                state <= S_FIN;
                            end else begin
                                err      <= 1'b0;
                                sa_clear <= 1'b1;
                                state    <= S_CLEAR;
                            end
                        end
                    end
                    S_CLEAR: begin
                        sa_start <= 1'b1;
                        state    <= S_START;
                    end
                    S_START: begin
                        wdog  <= '0;
                        state <= S_WAIT;
                    end
                    S_WAIT: begin
                        // A done arriving on the final watchdog count still wins.
                        if (sa_done) begin
                            state <= S_DRAIN;
                        end else if (wdog == WD_W'(TMO)) begin
                            err   <= 1'b1;
                            done  <= 1'b1;
                            state <= S_FIN;
                        end else begin
                            wdog <= wdog + WD_W'(1);
                        end
                    end
                    S_DRAIN: begin
                        if (dw_last_c) state <= S_NEXT;
                    end
                    S_NEXT: begin
                        mt_idx    <= mt_nxt_c;
                        nt_idx    <= nt_nxt_c;
                        sa_a_addr <= ADDR_W'(EXT_W'(a_base) + EXT_W'(mt_nxt_c) * EXT_W'(sa_k_param));
                        sa_b_addr <= ADDR_W'(EXT_W'(b_base) + EXT_W'(nt_nxt_c) * EXT_W'(sa_k_param));
                        if (last_tile_c) begin
                            done  <= 1'b1;
                            state <= S_FIN;
                        end else begin
                            sa_clear <= 1'b1;
                            state    <= S_CLEAR;
                        end
                    end
                    S_FIN: begin
                        busy          <= 1'b0;
                        cfg.cfg_ready <= 1'b1;
                        state         <= S_IDLE;
                    end
                    default: begin
                        busy          <= 1'b0;
                        cfg.cfg_ready <= 1'b1;
                        state         <= S_IDLE;
                    end
                endcase
            end
        end
    end

    sa_drain_writer #(.N(N)) u_drain (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (dw_start_c),
        .abort   (abort_c),
        .base    (tile_base_c),
        .data    (sa_out),
        .last_c  (dw_last_c),
        .c_wsbn  (c_wsbn),
        .c_waddr (c_waddr),
        .c_wdata (c_wdata)
    );

endmodule
